// File: rtl/pc_unit.sv
// Program counter with BOOT/RUN/HALT sequencing, prioritised redirects and an advance counter.
// Optional macro PC_COMPRESSED_EN enables 2-byte steps and 2-byte redirect alignment.
module pc_unit #(
   parameter int              XLEN         = 32,
   parameter logic [XLEN-1:0] RESET_VECTOR = '0,
   parameter logic [XLEN-1:0] TRAP_VECTOR  = XLEN'(32'h0000_0100),
   parameter int              CNT_W        = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             stall,
   input  logic             halt_req,
   input  logic             resume,
   input  logic             trap,
   input  logic             jump_en,
   input  logic [XLEN-1:0]  jump_target,
   input  logic             branch_taken,
   input  logic [XLEN-1:0]  branch_target,
   input  logic             is_compressed,
   output logic [XLEN-1:0]  pc,
   output logic [XLEN-1:0]  pc_next_seq,
   output logic             pc_valid,
   output logic             misalign_err,
   output logic             halted,
   output logic [CNT_W-1:0] adv_count
);

   typedef enum logic [1:0] {BOOT, RUN, HALT} state_e;

   state_e           state_q;
   logic [XLEN-1:0]  pc_q, pc_d;
   logic [CNT_W-1:0] cnt_q;
   logic             err_q, err_d;
   logic             adv_d;
   logic             valid_q, halted_q;
   logic [XLEN-1:0]  step;
   logic [XLEN-1:0]  align_mask;
   logic [XLEN-1:0]  jump_tgt;

`ifdef PC_COMPRESSED_EN
   assign step       = is_compressed ? XLEN'(2) : XLEN'(4);
   assign align_mask = XLEN'(1);
`else
   logic unused_is_compressed;
   assign unused_is_compressed = is_compressed;
   assign step       = XLEN'(4);
   assign align_mask = XLEN'(3);
`endif

   assign pc_next_seq = pc_q + step;
   // JALR semantics: bit 0 of the jump target is dropped before the alignment check.
   assign jump_tgt    = jump_target & ~XLEN'(1);

   // NOTE: every output of this block gets a default first, so no path leaves a latch.
   always_comb begin
      pc_d  = pc_q;
      err_d = 1'b0;
      adv_d = 1'b0;
      if (state_q == RUN) begin
         adv_d = 1'b1;
         if (trap) begin
            pc_d = TRAP_VECTOR;
         end else if (jump_en) begin
            err_d = (jump_tgt & align_mask) != '0;
            pc_d  = err_d ? TRAP_VECTOR : jump_tgt;
         end else if (branch_taken) begin
            err_d = (branch_target & align_mask) != '0;
            pc_d  = err_d ? TRAP_VECTOR : branch_target;
         end else if (stall) begin
            adv_d = 1'b0;
         end else begin
            pc_d = pc_next_seq;
         end
      end else if (state_q == HALT && trap) begin
         pc_d = TRAP_VECTOR;
      end
   end

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= BOOT;
         pc_q     <= RESET_VECTOR;
         cnt_q    <= '0;
         err_q    <= 1'b0;
         valid_q  <= 1'b0;
         halted_q <= 1'b0;
      end else begin
         pc_q  <= pc_d;
         cnt_q <= cnt_q + CNT_W'(adv_d);
         err_q <= err_d;
         case (state_q)
            BOOT: begin
               state_q  <= RUN;
               valid_q  <= 1'b1;
               halted_q <= 1'b0;
            end
            RUN: begin
               // A redirect in the halt_req cycle still lands; only later cycles freeze.
               if (halt_req) begin
                  state_q  <= HALT;
                  valid_q  <= 1'b0;
                  halted_q <= 1'b1;
               end
            end
            HALT: begin
               if (resume && !halt_req) begin
                  state_q  <= RUN;
                  valid_q  <= 1'b1;
                  halted_q <= 1'b0;
               end
            end
            default: begin
               state_q  <= BOOT;
               valid_q  <= 1'b0;
               halted_q <= 1'b0;
            end
         endcase
      end
   end

   assign pc           = pc_q;
   assign pc_valid     = valid_q;
   assign halted       = halted_q;
   assign misalign_err = err_q;
   assign adv_count    = cnt_q;

endmodule

// File: tb/tb_pc_unit.sv
// Directed scoreboard bench for pc_unit: each step queues its expected post-edge state,
// which is popped and compared one time unit after the rising edge.
module tb_pc_unit;

   logic        clk = 1'b0;
   logic        rst, stall, halt_req, resume, trap, jump_en, branch_taken, is_compressed;
   logic [31:0] jump_target, branch_target;
   logic [31:0] pc, pc_next_seq, adv_count;
   logic        pc_valid, misalign_err, halted;

   typedef struct {
      string       tag;
      logic [31:0] pc;
      logic        valid;
      logic        halted;
      logic        err;
      logic [31:0] cnt;
   } exp_t;

   exp_t exp_q[$];
   int   tests  = 0;
   int   failed = 0;

   pc_unit dut (
      .clk           (clk),
      .rst           (rst),
      .stall         (stall),
      .halt_req      (halt_req),
      .resume        (resume),
      .trap          (trap),
      .jump_en       (jump_en),
      .jump_target   (jump_target),
      .branch_taken  (branch_taken),
      .branch_target (branch_target),
      .is_compressed (is_compressed),
      .pc            (pc),
      .pc_next_seq   (pc_next_seq),
      .pc_valid      (pc_valid),
      .misalign_err  (misalign_err),
      .halted        (halted),
      .adv_count     (adv_count)
   );

   always #5 clk = ~clk;

   task automatic chk32(input string tag, input string what, input logic [31:0] obs,
                        input logic [31:0] expv);
      tests++;
      assert (obs === expv) else begin
         failed++;
         $error("FAIL %s %s observed=%h expected=%h", tag, what, obs, expv);
      end
   endtask

   task automatic chk1(input string tag, input string what, input logic obs, input logic expv);
      tests++;
      assert (obs === expv) else begin
         failed++;
         $error("FAIL %s %s observed=%b expected=%b", tag, what, obs, expv);
      end
   endtask

   // Drives one cycle of stimulus, queues the expected state after the edge, then checks it.
   task automatic step(input string tag, input logic r, input logic st, input logic hr,
                       input logic rs, input logic tr, input logic je, input logic [31:0] jt,
                       input logic br, input logic [31:0] bt,
                       input logic [31:0] e_pc, input logic e_v, input logic e_h,
                       input logic e_err, input logic [31:0] e_cnt);
      exp_t e;
      rst = r; stall = st; halt_req = hr; resume = rs; trap = tr;
      jump_en = je; jump_target = jt; branch_taken = br; branch_target = bt;
      exp_q.push_back('{tag, e_pc, e_v, e_h, e_err, e_cnt});
      @(posedge clk);
      #1;
      e = exp_q.pop_front();
      chk32(e.tag, "pc", pc, e.pc);
      chk1(e.tag, "pc_valid", pc_valid, e.valid);
      chk1(e.tag, "halted", halted, e.halted);
      chk1(e.tag, "misalign_err", misalign_err, e.err);
      chk32(e.tag, "adv_count", adv_count, e.cnt);
      chk32(e.tag, "pc_next_seq", pc_next_seq, e.pc + 32'd4);
   endtask

   initial begin
      rst = 1'b1; stall = 1'b0; halt_req = 1'b0; resume = 1'b0; trap = 1'b0;
      jump_en = 1'b0; branch_taken = 1'b0; is_compressed = 1'b0;
      jump_target = '0; branch_target = '0;

      //     tag            rst st hr rs tr je jt          br bt            pc          v  h  e  cnt
      step("reset0",        1, 0, 0, 0, 0, 0, 32'h0,     0, 32'h0,        32'h0,      0, 0, 0, 0);
      step("reset1",        1, 0, 0, 0, 0, 0, 32'h0,     0, 32'h0,        32'h0,      0, 0, 0, 0);
      step("boot_exit",     0, 0, 0, 0, 0, 0, 32'h0,     0, 32'h0,        32'h0,      1, 0, 0, 0);
      step("seq4",          0, 0, 0, 0, 0, 0, 32'h0,     0, 32'h0,        32'h4,      1, 0, 0, 1);
      step("seq8",          0, 0, 0, 0, 0, 0, 32'h0,     0, 32'h0,        32'h8,      1, 0, 0, 2);
      step("seqC",          0, 0, 0, 0, 0, 0, 32'h0,     0, 32'h0,        32'hC,      1, 0, 0, 3);
      step("seq10",         0, 0, 0, 0, 0, 0, 32'h0,     0, 32'h0,        32'h10,     1, 0, 0, 4);
      step("stall_branch",  0, 1, 0, 0, 0, 0, 32'h0,     1, 32'h40,       32'h40,     1, 0, 0, 5);
      step("stall_hold",    0, 1, 0, 0, 0, 0, 32'h0,     0, 32'h0,        32'h40,     1, 0, 0, 5);
`ifdef PC_COMPRESSED_EN
      step("jump_203",      0, 0, 0, 0, 0, 1, 32'h203,   0, 32'h0,        32'h202,    1, 0, 0, 6);
      step("after_jump",    0, 0, 0, 0, 0, 0, 32'h0,     0, 32'h0,        32'h206,    1, 0, 0, 7);
`else
      step("jump_203",      0, 0, 0, 0, 0, 1, 32'h203,   0, 32'h0,        32'h100,    1, 0, 1, 6);
      step("after_jump",    0, 0, 0, 0, 0, 0, 32'h0,     0, 32'h0,        32'h104,    1, 0, 0, 7);
`endif
      step("br_top",        0, 0, 0, 0, 0, 0, 32'h0,     1, 32'hFFFF_FFFC, 32'hFFFF_FFFC, 1, 0, 0, 8);
      step("wrap",          0, 0, 0, 0, 0, 0, 32'h0,     0, 32'h0,        32'h0,      1, 0, 0, 9);
      step("trap_jump",     0, 0, 0, 0, 1, 1, 32'h80,    0, 32'h0,        32'h100,    1, 0, 0, 10);
`ifdef PC_COMPRESSED_EN
      step("br_mis",        0, 0, 0, 0, 0, 0, 32'h0,     1, 32'h42,       32'h42,     1, 0, 0, 11);
`else
      step("br_mis",        0, 0, 0, 0, 0, 0, 32'h0,     1, 32'h42,       32'h100,    1, 0, 1, 11);
`endif
      step("br_20",         0, 0, 0, 0, 0, 0, 32'h0,     1, 32'h20,       32'h20,     1, 0, 0, 12);
      step("halt_req",      0, 0, 1, 0, 0, 0, 32'h0,     0, 32'h0,        32'h24,     0, 1, 0, 13);
      for (int i = 0; i < 5; i++)
         step("halt_ignore", 0, 1, 0, 0, 0, 1, 32'h300,   1, 32'h80,       32'h24,     0, 1, 0, 13);
      step("halt_resume",   0, 0, 1, 1, 0, 0, 32'h0,     0, 32'h0,        32'h24,     0, 1, 0, 13);
      step("resume",        0, 0, 0, 1, 0, 0, 32'h0,     0, 32'h0,        32'h24,     1, 0, 0, 13);
      step("seq28",         0, 0, 0, 0, 0, 0, 32'h0,     0, 32'h0,        32'h28,     1, 0, 0, 14);
      step("halt_again",    0, 0, 1, 0, 0, 0, 32'h0,     0, 32'h0,        32'h2C,     0, 1, 0, 15);
      step("halt_trap",     0, 0, 0, 0, 1, 0, 32'h0,     0, 32'h0,        32'h100,    0, 1, 0, 15);
      step("rst_in_halt",   1, 0, 0, 0, 0, 0, 32'h0,     1, 32'h80,       32'h0,      0, 0, 0, 0);
      step("boot_exit2",    0, 0, 0, 0, 0, 0, 32'h0,     0, 32'h0,        32'h0,      1, 0, 0, 0);
      step("rst_redirect",  1, 0, 0, 0, 1, 1, 32'h300,   0, 32'h0,        32'h0,      0, 0, 0, 0);
      step("boot_exit3",    0, 0, 0, 0, 0, 0, 32'h0,     0, 32'h0,        32'h0,      1, 0, 0, 0);
      step("seq4_again",    0, 0, 0, 0, 0, 0, 32'h0,     0, 32'h0,        32'h4,      1, 0, 0, 1);

      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

endmodule
